// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM bus arbiter.
//   state_t    : arbiter FSM states
//   CTRL_*     : control_bus encodings {ram_read, ram_write}
//   port_idx_t : requester index (port 0 = processor, port 1 = secondary master)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_WRITE = 2'b01;
  localparam logic [1:0] CTRL_READ  = 2'b10;

  typedef logic port_idx_t;

  function automatic logic [1:0] ctrl_for(input logic we);
    return we ? CTRL_WRITE : CTRL_READ;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin grant picker.
//   req0, req1  : pending requests
//   last_grant  : port that won the previous arbitration
//   grant_valid : at least one request pending
//   grant_idx   : winning port (only meaningful with grant_valid)
// A lone request always wins; on a tie the port that did not win last time
// is chosen. Kept as its own block so it can be widened to N ports.
import mem_arb_pkg::*;

module rr_pick2 (
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_grant,
  output logic      grant_valid,
  output port_idx_t grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and access sequencer for a shared single-port RAM.
// One complete transaction is granted at a time (round-robin), the command
// is held on the bus for MEM_LAT cycles, read data is captured into the
// granted port's rdata register and a one-cycle ack is returned.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req/we/addr/wdataN  : requester N command (held until ackN)
//   ackN, rdataN        : completion pulse and registered read data
//   address_bus         : RAM address (holds last value when idle)
//   wdata_bus           : RAM write data (holds last value when idle)
//   control_bus         : {ram_read, ram_write}
//   rdata_bus           : RAM read data
//   busy                : FSM not in IDLE
//
// MEM_LAT legal range is 1..7 (3-bit latency counter).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus idle, arbitrating; a grant registers the command
// ACCESS | command driven on the bus, latency counter running down
// ACK    | ack pulse to the granted port, bus idle, back to IDLE
import mem_arb_pkg::*;

module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] wdata_bus,
  output logic [1:0]        control_bus,
  input  logic [DATA_W-1:0] rdata_bus,
  output logic              busy
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic       cmd_we;
  // Port granted most recently; during ACCESS/ACK this is also the port
  // that owns the transaction in flight.
  port_idx_t  last_grant;
  logic       grant_valid;
  port_idx_t  grant_idx;
  logic       start_xfer;
  logic       end_access;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt   = state;
    start_xfer  = 1'b0;
    end_access  = 1'b0;
    control_bus = CTRL_IDLE;
    ack0        = 1'b0;
    ack1        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt  = ACCESS;
          start_xfer = 1'b1;
        end
      end
      ACCESS: begin
        control_bus = ctrl_for(cmd_we);
        if (lat_cnt == 3'd0) begin
          state_nxt  = ACK;
          end_access = 1'b1;
        end
      end
      ACK: begin
        ack0      = (last_grant == 1'b0);
        ack1      = (last_grant == 1'b1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= 3'd0;
      cmd_we      <= 1'b0;
      last_grant  <= 1'b1;
      address_bus <= '0;
      wdata_bus   <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state <= state_nxt;
      if (start_xfer) begin
        last_grant  <= grant_idx;
        cmd_we      <= grant_idx ? we1 : we0;
        address_bus <= grant_idx ? addr1 : addr0;
        wdata_bus   <= grant_idx ? wdata1 : wdata0;
        lat_cnt     <= LAT_LOAD;
      end else if (state == ACCESS && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      // Read data is sampled on the last ACCESS edge so it is stable with ack.
      if (end_access && !cmd_we) begin
        if (last_grant) begin
          rdata1 <= rdata_bus;
        end else begin
          rdata0 <= rdata_bus;
        end
      end
    end
  end

endmodule
